// File: rtl/data_memory_controller_if.sv
// Bundle between the control unit, the data-memory sequencer and the data memory.
// The slave modport is the sequencer; the master side is the control unit plus memory.
interface data_memory_controller_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] alu_address;
    logic [31:0] reg_data;
    logic [31:0] return_address;
    logic [31:0] mem_data_out;

    logic        mem_en;
    logic        mem_enr;
    logic        mem_enw;
    logic [31:0] mem_alu_address;
    logic [31:0] mem_stack_pointer;
    logic [31:0] mem_reg_data;
    logic [31:0] mem_add_data;
    logic        mem_address_data;
    logic        mem_stack_mem;

    logic        busy;
    logic        ack;
    logic        error;
    logic [31:0] load_data;
    logic [31:0] stack_pointer;

    modport slave (
        input  req, op, alu_address, reg_data, return_address, mem_data_out,
        output mem_en, mem_enr, mem_enw, mem_alu_address, mem_stack_pointer,
               mem_reg_data, mem_add_data, mem_address_data, mem_stack_mem,
               busy, ack, error, load_data, stack_pointer
    );

    modport master (
        output req, op, alu_address, reg_data, return_address, mem_data_out,
        input  mem_en, mem_enr, mem_enw, mem_alu_address, mem_stack_pointer,
               mem_reg_data, mem_add_data, mem_address_data, mem_stack_mem,
               busy, ack, error, load_data, stack_pointer
    );
endinterface

// File: rtl/data_memory_controller.sv
// Data-memory sequencer: one request at a time (LOAD/STORE/PUSH/POP/CALL/RET),
// owns the stack pointer and checks stack overflow/underflow before issuing.
module data_memory_controller #(
    parameter logic [31:0] STACK_BASE = 32'd224,
    parameter logic [31:0] STACK_INIT = 32'd256
) (
    input  logic                       clock,
    input  logic                       reset,
    data_memory_controller_if.slave    bus
);
    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;

    localparam logic MEM_STORE     = 1'b0;
    localparam logic STACK_STORE   = 1'b1;
    localparam logic ADDR_DATA_RF  = 1'b0;
    localparam logic ADDR_DATA_PC  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] alu_q;
    logic [31:0] reg_q;
    logic [31:0] ret_q;
    logic [31:0] sp_q;
    logic [31:0] load_q;
    logic        err_q;

    logic        req_bad;
    logic        op_rd;
    logic        op_push;
    logic        op_pop;

    // Checked against the live request so a failing op never reaches ISSUE.
    always_comb begin
        req_bad = 1'b0;
        if (bus.op > OP_RET)
            req_bad = 1'b1;
        else if ((bus.op == OP_PUSH || bus.op == OP_CALL) && sp_q == STACK_BASE)
            req_bad = 1'b1;
        else if ((bus.op == OP_POP || bus.op == OP_RET) && sp_q == STACK_INIT)
            req_bad = 1'b1;
    end

    assign op_rd   = (op_q == OP_LOAD) || (op_q == OP_POP) || (op_q == OP_RET);
    assign op_push = (op_q == OP_PUSH) || (op_q == OP_CALL);
    assign op_pop  = (op_q == OP_POP)  || (op_q == OP_RET);

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d               = state_q;
        bus.mem_enr           = 1'b0;
        bus.mem_enw           = 1'b0;
        bus.mem_stack_mem     = MEM_STORE;
        bus.mem_address_data  = ADDR_DATA_RF;
        bus.mem_stack_pointer = sp_q;
        unique case (state_q)
            S_IDLE:  if (bus.req) state_d = req_bad ? S_DONE : S_ISSUE;
            S_ISSUE: state_d = op_rd ? S_WAIT : S_DONE;
            S_WAIT:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Enables are gated with reset so a reset landing in ISSUE drops the access.
        if (state_q == S_ISSUE && !reset) begin
            bus.mem_enr = op_rd;
            bus.mem_enw = !op_rd;
        end
        if (op_push || op_pop)
            bus.mem_stack_mem = STACK_STORE;
        if (op_q == OP_CALL)
            bus.mem_address_data = ADDR_DATA_PC;
        if (op_push)
            bus.mem_stack_pointer = sp_q - 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= OP_LOAD;
            alu_q  <= '0;
            reg_q  <= '0;
            ret_q  <= '0;
            sp_q   <= STACK_INIT;
            load_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        op_q  <= bus.op;
                        alu_q <= bus.alu_address;
                        reg_q <= bus.reg_data;
                        ret_q <= bus.return_address;
                        err_q <= req_bad;
                    end
                end
                S_ISSUE: begin
                    if (op_push)
                        sp_q <= sp_q - 32'd1;
                end
                S_WAIT: begin
                    load_q <= bus.mem_data_out;
                    if (op_pop)
                        sp_q <= sp_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en          = ~reset;
    assign bus.mem_alu_address = alu_q;
    assign bus.mem_reg_data    = reg_q;
    assign bus.mem_add_data    = ret_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.ack             = (state_q == S_DONE);
    assign bus.error           = (state_q == S_DONE) && err_q;
    assign bus.load_data       = load_q;
    assign bus.stack_pointer   = sp_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: directed scenarios then random ops, checked
// against a word-array/stack reference model with a synchronous-read memory model.
module tb_data_memory_controller;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    data_memory_controller_if bus();

    data_memory_controller #(.STACK_BASE(32'd224), .STACK_INIT(32'd256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Data memory: one-cycle synchronous read, write on the edge ending the access.
    bit [31:0] mem [256];
    bit [31:0] rd_q;
    wire [31:0] acc_addr  = bus.mem_stack_mem ? bus.mem_stack_pointer : bus.mem_alu_address;
    wire [31:0] acc_wdata = bus.mem_address_data ? bus.mem_add_data : bus.mem_reg_data;
    assign bus.mem_data_out = rd_q;
    always @(posedge clock) begin
        if (bus.mem_en && bus.mem_enw) mem[acc_addr[7:0]] <= acc_wdata;
        if (bus.mem_en && bus.mem_enr) rd_q <= mem[acc_addr[7:0]];
    end

    // Reference model
    int        ref_sp = 256;
    bit [31:0] ref_mem [256];
    logic [31:0] ref_load = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] ra);
        bit rd, wr, stk, bad;
        int exp_lat, lat, nw, nr;
        logic [31:0] exp_addr, got_addr, got_err;
        logic got_stk, got_sel;
        rd  = (o == 3'd0) || (o == 3'd3) || (o == 3'd5);
        wr  = (o == 3'd1) || (o == 3'd2) || (o == 3'd4);
        stk = (o >= 3'd2) && (o <= 3'd5);
        bad = (o > 3'd5) || ((o == 3'd2 || o == 3'd4) && ref_sp == 224)
                         || ((o == 3'd3 || o == 3'd5) && ref_sp == 256);
        exp_lat  = bad ? 1 : (rd ? 3 : 2);
        exp_addr = (o <= 3'd1) ? a : ((o == 3'd2 || o == 3'd4) ? 32'(ref_sp - 1) : 32'(ref_sp));

        @(posedge clock); #1;
        bus.req = 1'b1; bus.op = o; bus.alu_address = a; bus.reg_data = d; bus.return_address = ra;
        @(posedge clock); #1;
        // Scramble the inputs so only latched values can produce a correct result.
        bus.req = 1'b0; bus.op = 3'($urandom); bus.alu_address = $urandom;
        bus.reg_data = $urandom; bus.return_address = $urandom;
        lat = 0; nw = 0; nr = 0; got_addr = '0; got_err = '0; got_stk = 1'b0; got_sel = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (c > 1) begin @(posedge clock); #1; end
            if (bus.mem_enw || bus.mem_enr) begin
                if (bus.mem_enw) nw++; else nr++;
                got_addr = acc_addr; got_stk = bus.mem_stack_mem; got_sel = bus.mem_address_data;
            end
            if (bus.ack) begin lat = c; got_err = 32'(bus.error); end
        end
        check("ack_latency", 32'(lat), 32'(exp_lat));
        check("error", got_err, 32'(bad));
        check("write_count", 32'(nw), 32'(!bad && wr));
        check("read_count", 32'(nr), 32'(!bad && rd));
        if (!bad) begin
            check("access_addr", got_addr, exp_addr);
            check("stack_sel", 32'(got_stk), 32'(stk));
            if (wr) check("addr_data_sel", 32'(got_sel), 32'(o == 3'd4));
        end
        if (!bad) begin
            case (o)
                3'd0: ref_load = ref_mem[a[7:0]];
                3'd1: ref_mem[a[7:0]] = d;
                3'd2: begin ref_sp--; ref_mem[ref_sp] = d; end
                3'd4: begin ref_sp--; ref_mem[ref_sp] = ra; end
                3'd3, 3'd5: begin ref_load = ref_mem[ref_sp]; ref_sp++; end
                default: ;
            endcase
        end
        check("load_data", bus.load_data, ref_load);
        check("stack_pointer", bus.stack_pointer, 32'(ref_sp));
        @(posedge clock); #1;
        if (!bad && wr) check("mem_word", mem[exp_addr[7:0]], ref_mem[exp_addr[7:0]]);
        check("ack_one_cycle", 32'(bus.ack), 32'd0);
        check("idle_after", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acks, nw, nr;
        bus.req = 1'b0; bus.op = '0; bus.alu_address = '0; bus.reg_data = '0; bus.return_address = '0;
        reset = 1'b1;

        // Reset for two cycles, then hold reset with a live request.
        repeat (2) @(posedge clock);
        #1;
        check("rst_sp", bus.stack_pointer, 32'd256);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_enr", 32'(bus.mem_enr), 32'd0);
        check("rst_enw", 32'(bus.mem_enw), 32'd0);
        check("rst_en", 32'(bus.mem_en), 32'd0);
        check("rst_load", bus.load_data, 32'd0);
        bus.req = 1'b1; bus.op = 3'd2; bus.reg_data = 32'h55;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_busy", 32'(bus.busy), 32'd0);
        check("rst_req_sp", bus.stack_pointer, 32'd256);
        bus.req = 1'b0;
        reset = 1'b0;
        #1;
        check("en_after_rst", 32'(bus.mem_en), 32'd1);

        run_op(3'd1, 32'd2, 32'd4, 32'd0);   // STORE
        run_op(3'd0, 32'd2, 32'd0, 32'd0);   // LOAD -> 4
        run_op(3'd2, 32'd0, 32'd4, 32'd0);   // PUSH
        run_op(3'd4, 32'd0, 32'd0, 32'd16);  // CALL
        run_op(3'd5, 32'd0, 32'd0, 32'd0);   // RET -> 16
        run_op(3'd3, 32'd0, 32'd0, 32'd0);   // POP -> 4

        // Fill the stack, overflow once, then drain it and underflow once.
        for (int i = 0; i < 32; i++) run_op(3'd2, 32'd0, 32'(100 + i), 32'd0);
        check("full_sp", bus.stack_pointer, 32'd224);
        run_op(3'd2, 32'd0, 32'hBAD, 32'd0);
        for (int i = 0; i < 32; i++) run_op(3'd3, 32'd0, 32'd0, 32'd0);
        run_op(3'd3, 32'd0, 32'd0, 32'd0);
        run_op(3'd5, 32'd0, 32'd0, 32'd0);
        run_op(3'd7, 32'd3, 32'd0, 32'd0);
        run_op(3'd6, 32'd3, 32'd0, 32'd0);

        // Reset arriving while a PUSH is in ISSUE.
        @(posedge clock); #1;
        bus.req = 1'b1; bus.op = 3'd2; bus.reg_data = 32'hDEAD;
        @(posedge clock); #1;
        bus.req = 1'b0;
        reset = 1'b1;
        #1;
        check("issue_rst_enw", 32'(bus.mem_enw), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("issue_rst_sp", bus.stack_pointer, 32'd256);
        check("issue_rst_busy", 32'(bus.busy), 32'd0);
        check("issue_rst_mem255", mem[255], ref_mem[255]);
        ref_load = '0;
        check("issue_rst_load", bus.load_data, ref_load);

        // Requests during a LOAD in flight are dropped.
        @(posedge clock); #1;
        bus.req = 1'b1; bus.op = 3'd0; bus.alu_address = 32'd2;
        @(posedge clock); #1;
        bus.op = 3'd1; bus.alu_address = 32'd5; bus.reg_data = 32'h77;
        acks = 0; nw = 0; nr = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin @(posedge clock); #1; end
            bus.req = (c <= 2);
            if (bus.ack) acks++;
            if (bus.mem_enw) nw++;
            if (bus.mem_enr) nr++;
        end
        bus.req = 1'b0;
        ref_load = ref_mem[2];
        check("busy_req_acks", 32'(acks), 32'd1);
        check("busy_req_writes", 32'(nw), 32'd0);
        check("busy_req_reads", 32'(nr), 32'd1);
        check("busy_req_load", bus.load_data, ref_load);

        // Random traffic; stores/loads stay below the stack region.
        for (int i = 0; i < 80; i++)
            run_op(3'($urandom_range(0, 7)), 32'($urandom_range(0, 223)), $urandom, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Sequencer that owns the data-memory port of the Simple RISC datapath. It accepts one memory request at a time from the control unit: LOAD, STORE, PUSH, POP, CALL or RET. It holds the architectural stack pointer and drives the data memory's enables, address/stack select and data-source select. Stack overflow and underflow checks are done in hardware, and a one-cycle `ack` returns the result to the control unit.

## Interface
Parameters:
- STACK_BASE, 224: lowest word address the stack may occupy; stack full when SP == STACK_BASE.
- STACK_INIT, 256: reset/empty SP value; stack occupies STACK_BASE..255, grows downward.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- req  in  1  request strobe, sampled only in IDLE.
- op  in  3  0 LOAD, 1 STORE, 2 PUSH, 3 POP, 4 CALL, 5 RET, 6–7 invalid.
- alu_address  in  32  effective address for LOAD/STORE.
- reg_data  in  32  register-file write data (STORE/PUSH).
- return_address  in  32  PC+1 for CALL.
- mem_data_out  in  32  data memory read data.
- mem_en  out  1  memory enable.
- mem_enr  out  1  read enable.
- mem_enw  out  1  write enable.
- mem_alu_address  out  32  latched alu_address.
- mem_stack_pointer  out  32  stack address for current access.
- mem_reg_data, mem_add_data  out  32  latched reg_data / return_address.
- mem_address_data  out  1  addressDataRF or addressDataPC.
- mem_stack_mem  out  1  memStore or stackStore.
- busy  out  1  high in every state except IDLE.
- ack  out  1  one-cycle completion pulse.
- error  out  1  valid with ack: overflow, underflow or invalid op.
- load_data  out  32  read result (LOAD/POP/RET); held until next read completes.
- stack_pointer  out  32  architectural SP register.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: on req=1, latch op, alu_address, reg_data and return_address.
  - If the op is invalid, or the stack check fails (PUSH/CALL with SP == STACK_BASE; POP/RET with SP == STACK_INIT), go to DONE with error=1.
  - Otherwise go to ISSUE.
- ISSUE, one cycle: assert mem_enr (LOAD/POP/RET) or mem_enw (STORE/PUSH/CALL).
  - Writes go to DONE; reads go to WAIT.
- WAIT: capture mem_data_out into load_data at end of cycle. Go to DONE.
- DONE: ack=1 for one cycle, then IDLE.
- Per-op selects during ISSUE:
  - LOAD/STORE: stack_mem=memStore, address_data=addressDataRF.
  - PUSH: stack_mem=stackStore, address_data=addressDataRF, mem_stack_pointer=SP-1.
  - CALL: same as PUSH except address_data=addressDataPC.
  - POP/RET: stack_mem=stackStore, mem_stack_pointer=SP.
- SP update:
  - PUSH/CALL: SP <= SP-1 at end of ISSUE.
  - POP/RET: SP <= SP+1 at end of WAIT.
  - Error cases: SP unchanged, no memory enable asserted, load_data unchanged.
- SP arithmetic is 32-bit. It cannot leave [STACK_BASE, STACK_INIT] because of the checks.
- req while busy is ignored, not queued.
- Reset values: state=IDLE, SP=STACK_INIT, load_data=0, busy=0, ack=0, error=0, mem_enr=mem_enw=0, latched address/data registers=0, selects=memStore/addressDataRF.
- mem_en = ~reset. mem_enr and mem_enw are gated with ~reset combinationally, so reset in ISSUE drops the access: no write commits and SP is not updated.

## Timing
- Enables and selects are Moore outputs decoded from state and latched registers, not from live inputs.
- Write latency: req edge → ISSUE → DONE; ack in the 2nd cycle after the req edge.
- Read latency: ISSUE → WAIT → DONE; ack in the 3rd cycle. load_data is valid from DONE onward.
- Error latency: ack+error in the cycle after the req edge.
- Memory read data must be valid in WAIT (one-cycle synchronous read). Writes commit on the edge ending ISSUE.
- Back-to-back requests: next req accepted in IDLE, at the earliest one cycle after DONE.

## Test plan
- Reset: assert reset 2 cycles → SP=256, busy=0, ack=0, all enables 0. Hold reset with req=1 → no state change.
- STORE alu_address=2, reg_data=4 → mem_enw 1 cycle with memStore/addressDataRF, ack at +2. Then LOAD address 2 → load_data=4, ack at +3.
- PUSH reg_data=4 → write at 255, SP=255. CALL return_address=16 → write at 254 with addressDataPC, SP=254. RET → load_data=16, SP=255. POP → load_data=4, SP=256.
- 32 PUSHes → SP=224, no error. 33rd PUSH → ack+error at +1, no mem_enw, SP=224. POP at SP=256 → error, SP unchanged. op=7 → error.
- Reset asserted during ISSUE of a PUSH → mem_enw=0 that cycle, SP=256, state IDLE, memory word 255 unchanged.
- req pulsed in ISSUE/WAIT of a LOAD → ignored, exactly one ack.
